// File: rtl/div128x64_seq.sv
// Radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Each accepted operation either finishes at once (divide by zero, overflow) or runs W iterations.
module div128x64_seq #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  // Partial remainder fits in W bits, but the shifted trial value needs W+1.
  logic [W:0]      t;
  logic            t_ge;
  logic [W-1:0]    r_nxt;

  always_comb begin
    t     = {r_q, q_q[W-1]};
    t_ge  = (t >= {1'b0, d_q});
    r_nxt = t_ge ? W'(t - {1'b0, d_q}) : t[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = '1;
            rem_d   = dividend[W-1:0];
          end else if (dividend[2*W-1:W] >= divisor) begin
            state_d = DONE;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
          end else begin
            state_d = RUN;
            r_d     = dividend[2*W-1:W];
            q_d     = dividend[W-1:0];
            d_d     = divisor;
            cnt_d   = CW'(W-1);
          end
        end
      end
      RUN: begin
        r_d   = r_nxt;
        q_d   = {q_q[W-2:0], t_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = {q_q[W-2:0], t_ge};
          rem_d   = r_nxt;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div128x64_seq.sv
// Directed and scoreboard-checked stimulus for div128x64_seq.
module tb_div128x64_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dividend;
  logic [63:0]  divisor;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  quotient;
  logic [63:0]  remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] A = 64'hDEADBEEF_CAFEBABE;
  localparam logic [63:0] B = 64'h01234567_89ABCDEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  div128x64_seq #(.W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // Issue one operation and wait for the result. lat = edges after the accept edge.
  task automatic run_op(input logic [127:0] dvd, input logic [63:0] dvs,
                        output int lat, output int busy_hi);
    int n;
    n = 0;
    busy_hi = 0;
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_hi++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (quotient !== 64'h0 || remainder !== 64'h0) begin
      n_fail++; $display("FAIL reset_qr got q=%h r=%h exp 0/0", quotient, remainder); end
    n_tests++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got dbz=%b ovf=%b exp 0/0", div_by_zero, overflow); end
  endtask

  task automatic test_normal();
    int lat, busy;
    run_op({64'h0, A} * {64'h0, B} + 128'd5, B, lat, busy);
    n_tests++; if (lat !== 64) begin n_fail++; $display("FAIL normal_latency got=%0d exp=64", lat); end
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL normal_in_ready_busy got=%0d cycles high exp=0", busy); end
    n_tests++; if (quotient !== A) begin n_fail++; $display("FAIL normal_quotient got=%h exp=%h", quotient, A); end
    n_tests++; if (remainder !== 64'd5) begin n_fail++; $display("FAIL normal_remainder got=%h exp=5", remainder); end
    n_tests++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL normal_flags got dbz=%b ovf=%b exp 0/0", div_by_zero, overflow); end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat, busy;
    run_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'h0, lat, busy);
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=0", lat); end
    n_tests++; if (div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL dbz_flags got dbz=%b ovf=%b exp 1/0", div_by_zero, overflow); end
    n_tests++; if (quotient !== ONES || remainder !== 64'hFEDC_BA98_7654_3210) begin
      n_fail++; $display("FAIL dbz_qr got q=%h r=%h exp q=%h r=fedcba9876543210", quotient, remainder, ONES); end
    consume();
  endtask

  task automatic test_overflow();
    int lat, busy;
    run_op({64'h1, 64'h0}, 64'h1, lat, busy);
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=0", lat); end
    n_tests++; if (overflow !== 1'b1 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL ovf_flags got ovf=%b dbz=%b exp 1/0", overflow, div_by_zero); end
    n_tests++; if (quotient !== ONES || remainder !== 64'h0) begin
      n_fail++; $display("FAIL ovf_qr got q=%h r=%h exp all-ones/0", quotient, remainder); end
    consume();
    run_op({64'hFFFF_FFFF_FFFF_FFFE, ONES}, ONES, lat, busy);
    n_tests++; if (lat !== 64) begin n_fail++; $display("FAIL edge_latency got=%0d exp=64", lat); end
    n_tests++; if (overflow !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL edge_flags got ovf=%b dbz=%b exp 0/0", overflow, div_by_zero); end
    n_tests++; if (quotient !== ONES || remainder !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL edge_qr got q=%h r=%h exp all-ones/fffffffffffffffe", quotient, remainder); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat, busy;
    run_op(128'd1000, 64'd3, lat, busy);
    n_tests++; if (quotient !== 64'd333 || remainder !== 64'd1) begin
      n_fail++; $display("FAIL bp_first got q=%0d r=%0d exp 333/1", quotient, remainder); end
    dividend = 128'd100; divisor = 64'd7; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 64'd333 || remainder !== 64'd1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got ov=%b ir=%b q=%0d r=%0d exp 1/0/333/1",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    consume();
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pending_accept got ir=%b exp 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat !== 64 || quotient !== 64'd14 || remainder !== 64'd2) begin
      n_fail++; $display("FAIL bp_second got lat=%0d q=%0d r=%0d exp 64/14/2", lat, quotient, remainder); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, busy, n;
    n = 0;
    dividend = {64'h0, A} * {64'h0, B} + 128'd5; divisor = B; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_handshake got ir=%b ov=%b exp 1/0", in_ready, out_valid); end
    n_tests++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags got dbz=%b ovf=%b exp 0/0", div_by_zero, overflow); end
    run_op(128'd100, 64'd7, lat, busy);
    n_tests++; if (lat !== 64 || quotient !== 64'd14 || remainder !== 64'd2) begin
      n_fail++; $display("FAIL rstmid_after got lat=%0d q=%0d r=%0d exp 64/14/2", lat, quotient, remainder); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, busy, mode;
    logic [63:0]  d, hi, lo;
    logic [127:0] dvd, recon;
    for (int k = 0; k < 1000; k++) begin
      mode = $urandom_range(0, 9);
      d  = {$urandom, $urandom};
      hi = {$urandom, $urandom};
      lo = {$urandom, $urandom};
      if (mode == 0) d = '0;
      else if (mode == 1) begin
        if (d == '0) d = 64'd1;
        hi = hi | d;
      end else begin
        if (mode == 2) d = 64'($urandom_range(1, 1000));
        if (d == '0) d = 64'd1;
        hi = hi % d;
      end
      dvd = {hi, lo};
      run_op(dvd, d, lat, busy);
      n_tests++;
      if (mode == 0) begin
        if (lat !== 0 || div_by_zero !== 1'b1 || overflow !== 1'b0 || quotient !== ONES || remainder !== lo) begin
          n_fail++;
          $display("FAIL rand_dbz op %0d got lat=%0d dbz=%b ovf=%b q=%h r=%h exp r=%h", k, lat,
                   div_by_zero, overflow, quotient, remainder, lo);
        end
      end else if (mode == 1) begin
        if (lat !== 0 || div_by_zero !== 1'b0 || overflow !== 1'b1 || quotient !== ONES || remainder !== 64'h0) begin
          n_fail++;
          $display("FAIL rand_ovf op %0d got lat=%0d dbz=%b ovf=%b q=%h r=%h", k, lat,
                   div_by_zero, overflow, quotient, remainder);
        end
      end else begin
        recon = {64'h0, quotient} * {64'h0, d} + {64'h0, remainder};
        if (lat !== 64 || recon !== dvd || remainder >= d || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_div op %0d got lat=%0d q=%h r=%h q*d+r=%h exp dividend=%h d=%h", k, lat,
                   quotient, remainder, recon, dvd, d);
        end
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_by_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
